bbox_pipe: RTL and testbench



---
 rtl/bbox_pipe_if.sv | 24 ++
 rtl/bbox_pipe.sv | 157 +++++++++++++++
 tb/tb_bbox_pipe.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bbox_pipe_if.sv
// Vertex-set input and bounding-box output handshake bundle for bbox_pipe.
// slave is the unit's view; master is the view of whatever drives it.
interface bbox_pipe_if #(
    parameter int W = 16
);
    logic                IN_VALID;
    logic                IN_READY;
    logic signed [W-1:0] V0X, V1X, V2X;
    logic signed [W-1:0] V0Y, V1Y, V2Y;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic signed [W-1:0] XMIN, XMAX, YMIN, YMAX;
    logic                CULLED;

    modport master (
        output IN_VALID, V0X, V1X, V2X, V0Y, V1Y, V2Y, OUT_READY,
        input  IN_READY, OUT_VALID, XMIN, XMAX, YMIN, YMAX, CULLED
    );

    modport slave (
        input  IN_VALID, V0X, V1X, V2X, V0Y, V1Y, V2Y, OUT_READY,
        output IN_READY, OUT_VALID, XMIN, XMAX, YMIN, YMAX, CULLED
    );
endinterface

// File: rtl/bbox_pipe.sv
// Two-stage triangle bounding-box unit: S1 takes per-axis min/max, S2 rounds
// to the pixel grid, culls offscreen boxes and clamps to the screen.
module bbox_pipe #(
    parameter int W        = 16,
    parameter int FRAC     = 6,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter bit CULL_EN  = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    bbox_pipe_if.slave       bus,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] CULL_CNT
);
    typedef logic signed [W-1:0] sw_t;
    typedef logic signed [W:0]   sx_t;

    localparam int  HALF_I = 1 << (FRAC - 1);
    localparam int  XLIM_I = (SCREEN_W - 1) << FRAC;
    localparam int  YLIM_I = (SCREEN_H - 1) << FRAC;
    localparam sx_t HALF   = sx_t'(HALF_I);
    localparam sx_t XLIM   = sx_t'(XLIM_I);
    localparam sx_t YLIM   = sx_t'(YLIM_I);

    function automatic sw_t min3(input sw_t a, input sw_t b, input sw_t c);
        sw_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic sw_t max3(input sw_t a, input sw_t b, input sw_t c);
        sw_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // One extra bit so the largest positive vertex plus one half cannot wrap.
    function automatic sx_t round_px(input sw_t v);
        sx_t s;
        s = {v[W-1], v};
        s = s + HALF;
        s[FRAC-1:0] = '0;
        return s;
    endfunction

    function automatic sw_t clamp_px(input sx_t v, input sx_t hi);
        if (v[W]) return '0;
        if (v > hi) return hi[W-1:0];
        return v[W-1:0];
    endfunction

    logic             s1_v_q, s1_v_d;
    sw_t              s1_xmin_q, s1_xmin_d, s1_xmax_q, s1_xmax_d;
    sw_t              s1_ymin_q, s1_ymin_d, s1_ymax_q, s1_ymax_d;
    logic             s2_v_q, s2_v_d;
    sw_t              xmin_q, xmin_d, xmax_q, xmax_d;
    sw_t              ymin_q, ymin_d, ymax_q, ymax_d;
    logic             cull_q, cull_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic out_valid, s2_adv, s1_adv, cull;
    sx_t  rxmin, rxmax, rymin, rymax;

    always_comb begin
        // A culled box in S2 never presents, so it always drains next edge.
        out_valid = s2_v_q && !(CULL_EN && cull_q);
        s2_adv    = !out_valid || bus.OUT_READY;
        s1_adv    = !s1_v_q || s2_adv;

        rxmin = round_px(s1_xmin_q);
        rxmax = round_px(s1_xmax_q);
        rymin = round_px(s1_ymin_q);
        rymax = round_px(s1_ymax_q);
        cull  = rxmax[W] || rymax[W] || (rxmin > XLIM) || (rymin > YLIM);

        s1_v_d    = s1_v_q;
        s1_xmin_d = s1_xmin_q;
        s1_xmax_d = s1_xmax_q;
        s1_ymin_d = s1_ymin_q;
        s1_ymax_d = s1_ymax_q;
        s2_v_d    = s2_v_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        cull_d    = cull_q;
        cnt_d     = cnt_q;

        if (s1_adv) begin
            s1_v_d = bus.IN_VALID;
            if (bus.IN_VALID) begin
                s1_xmin_d = min3(bus.V0X, bus.V1X, bus.V2X);
                s1_xmax_d = max3(bus.V0X, bus.V1X, bus.V2X);
                s1_ymin_d = min3(bus.V0Y, bus.V1Y, bus.V2Y);
                s1_ymax_d = max3(bus.V0Y, bus.V1Y, bus.V2Y);
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                xmin_d = clamp_px(rxmin, XLIM);
                xmax_d = clamp_px(rxmax, XLIM);
                ymin_d = clamp_px(rymin, YLIM);
                ymax_d = clamp_px(rymax, YLIM);
                cull_d = cull;
            end
        end

        if (CNT_CLR) begin
            cnt_d = '0;
        end else if (s2_v_q && cull_q && s2_adv && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_v_q    <= 1'b0;
            s1_xmin_q <= '0;
            s1_xmax_q <= '0;
            s1_ymin_q <= '0;
            s1_ymax_q <= '0;
            s2_v_q    <= 1'b0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            cull_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_xmin_q <= s1_xmin_d;
            s1_xmax_q <= s1_xmax_d;
            s1_ymin_q <= s1_ymin_d;
            s1_ymax_q <= s1_ymax_d;
            s2_v_q    <= s2_v_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            cull_q    <= cull_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.IN_READY  = s1_adv;
    assign bus.OUT_VALID = out_valid;
    assign bus.XMIN      = xmin_q;
    assign bus.XMAX      = xmax_q;
    assign bus.YMIN      = ymin_q;
    assign bus.YMAX      = ymax_q;
    assign bus.CULLED    = CULL_EN ? 1'b0 : cull_q;
    assign CULL_CNT      = cnt_q;
endmodule

// File: tb/tb_bbox_pipe.sv
// Bench for bbox_pipe: a dropping (CULL_EN=1, narrow counter) and a flagging
// (CULL_EN=0) instance, each checked against an arithmetic box model.
module tb_bbox_pipe;
    localparam int W        = 16;
    localparam int FRAC     = 6;
    localparam int SW       = 320;
    localparam int SH       = 240;
    localparam int CNTA_W   = 4;
    localparam int XL       = (SW - 1) << FRAC;
    localparam int YL       = (SH - 1) << FRAC;
    localparam int CNTA_MAX = (1 << CNTA_W) - 1;
    localparam int ONE      = 1 << FRAC;

    typedef struct { int x[3]; int y[3]; } tri_t;
    typedef struct { int xmin; int xmax; int ymin; int ymax; bit culled; } box_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr_a = 1'b0;
    logic              clr_b = 1'b0;
    logic [CNTA_W-1:0] cnt_a;
    logic [15:0]       cnt_b;

    bbox_pipe_if #(.W(W)) ia ();
    bbox_pipe_if #(.W(W)) ib ();

    bbox_pipe #(.W(W), .FRAC(FRAC), .SCREEN_W(SW), .SCREEN_H(SH),
                .CULL_EN(1'b1), .CNT_W(CNTA_W)) dut_a (
        .CLK(clk), .RST(rst), .bus(ia), .CNT_CLR(clr_a), .CULL_CNT(cnt_a));

    bbox_pipe #(.W(W), .FRAC(FRAC), .SCREEN_W(SW), .SCREEN_H(SH),
                .CULL_EN(1'b0), .CNT_W(16)) dut_b (
        .CLK(clk), .RST(rst), .bus(ib), .CNT_CLR(clr_b), .CULL_CNT(cnt_b));

    always #5 clk = ~clk;

    tri_t src_a[$], src_b[$];
    box_t q_a[$], q_b[$];
    int   n_vec = 0, n_err = 0;
    int   occ_b = 0, exp_a = 0, exp_b = 0;
    int   rdy_mode = 0, cyc = 0;

    function automatic int rnd_px(input int v);
        int s, q;
        s = v + ONE / 2;
        q = s / ONE;
        if (s < 0 && (s % ONE) != 0) q = q - 1;
        return q * ONE;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic box_t model(input tri_t t);
        box_t b;
        int mnx = t.x[0], mxx = t.x[0], mny = t.y[0], mxy = t.y[0];
        int rxn, rxx, ryn, ryx;
        for (int i = 1; i < 3; i++) begin
            if (t.x[i] < mnx) mnx = t.x[i];
            if (t.x[i] > mxx) mxx = t.x[i];
            if (t.y[i] < mny) mny = t.y[i];
            if (t.y[i] > mxy) mxy = t.y[i];
        end
        rxn = rnd_px(mnx); rxx = rnd_px(mxx);
        ryn = rnd_px(mny); ryx = rnd_px(mxy);
        b.culled = (rxx < 0) || (ryx < 0) || (rxn > XL) || (ryn > YL);
        b.xmin = clampi(rxn, XL); b.xmax = clampi(rxx, XL);
        b.ymin = clampi(ryn, YL); b.ymax = clampi(ryx, YL);
        return b;
    endfunction

    function automatic tri_t mk_tri(input int x0, input int x1, input int x2,
                                    input int y0, input int y1, input int y2);
        tri_t t;
        t.x[0] = x0; t.x[1] = x1; t.x[2] = x2;
        t.y[0] = y0; t.y[1] = y1; t.y[2] = y2;
        return t;
    endfunction

    function automatic int rand_coord(input int span, input int off);
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, span)) - off;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        box_t b;
        bit acc_a, acc_b, out_a, out_b;
        if (src_a.size() > 0) begin
            ia.IN_VALID = 1'b1;
            ia.V0X = W'(src_a[0].x[0]); ia.V1X = W'(src_a[0].x[1]); ia.V2X = W'(src_a[0].x[2]);
            ia.V0Y = W'(src_a[0].y[0]); ia.V1Y = W'(src_a[0].y[1]); ia.V2Y = W'(src_a[0].y[2]);
        end else ia.IN_VALID = 1'b0;
        if (src_b.size() > 0) begin
            ib.IN_VALID = 1'b1;
            ib.V0X = W'(src_b[0].x[0]); ib.V1X = W'(src_b[0].x[1]); ib.V2X = W'(src_b[0].x[2]);
            ib.V0Y = W'(src_b[0].y[0]); ib.V1Y = W'(src_b[0].y[1]); ib.V2Y = W'(src_b[0].y[2]);
        end else ib.IN_VALID = 1'b0;
        if (rdy_mode == 1) begin
            ia.OUT_READY = (cyc % 4 == 0) || (cyc % 4 == 3);
            ib.OUT_READY = (cyc % 4 == 0) || (cyc % 4 == 3);
        end else if (rdy_mode == 2) begin
            ia.OUT_READY = 1'($urandom_range(0, 1));
            ib.OUT_READY = 1'($urandom_range(0, 1));
        end
        #1;
        if (ia.OUT_VALID) begin
            if (q_a.size() == 0) chk("a_unexpected_out", 32'(ia.OUT_VALID), 32'(0));
            else begin
                chk("a_xmin", 32'(ia.XMIN), q_a[0].xmin);
                chk("a_xmax", 32'(ia.XMAX), q_a[0].xmax);
                chk("a_ymin", 32'(ia.YMIN), q_a[0].ymin);
                chk("a_ymax", 32'(ia.YMAX), q_a[0].ymax);
                chk("a_culled", 32'(ia.CULLED), 32'(0));
            end
        end
        if (ib.OUT_VALID) begin
            if (q_b.size() == 0) chk("b_unexpected_out", 32'(ib.OUT_VALID), 32'(0));
            else begin
                chk("b_xmin", 32'(ib.XMIN), q_b[0].xmin);
                chk("b_xmax", 32'(ib.XMAX), q_b[0].xmax);
                chk("b_ymin", 32'(ib.YMIN), q_b[0].ymin);
                chk("b_ymax", 32'(ib.YMAX), q_b[0].ymax);
                chk("b_culled", 32'(ib.CULLED), 32'(q_b[0].culled));
            end
        end
        // Input stalls only when two boxes are in flight and the head is blocked.
        chk("b_in_ready", 32'(ib.IN_READY), (occ_b == 2 && !ib.OUT_READY) ? 32'(0) : 32'(1));
        out_a = ia.OUT_VALID && ia.OUT_READY;
        acc_a = ia.IN_VALID && ia.IN_READY;
        out_b = ib.OUT_VALID && ib.OUT_READY;
        acc_b = ib.IN_VALID && ib.IN_READY;
        if (out_a && q_a.size() > 0) void'(q_a.pop_front());
        if (out_b && q_b.size() > 0) begin void'(q_b.pop_front()); occ_b--; end
        if (acc_a) begin
            b = model(src_a[0]);
            void'(src_a.pop_front());
            if (b.culled) exp_a = (exp_a >= CNTA_MAX) ? CNTA_MAX : exp_a + 1;
            else q_a.push_back(b);
        end
        if (acc_b) begin
            b = model(src_b[0]);
            void'(src_b.pop_front());
            q_b.push_back(b);
            occ_b++;
            if (b.culled && exp_b < 65535) exp_b++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (i >= 4 && src_a.size() == 0 && src_b.size() == 0 &&
                q_a.size() == 0 && q_b.size() == 0) break;
            tick();
        end
        chk("drain_timeout", src_a.size() + src_b.size() + q_a.size() + q_b.size(), 32'(0));
    endtask

    task automatic push_both(input tri_t t);
        src_a.push_back(t);
        src_b.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tri_t t;
        ia.IN_VALID = 1'b0; ib.IN_VALID = 1'b0;
        ia.OUT_READY = 1'b1; ib.OUT_READY = 1'b1;
        ia.V0X = '0; ia.V1X = '0; ia.V2X = '0; ia.V0Y = '0; ia.V1Y = '0; ia.V2Y = '0;
        ib.V0X = '0; ib.V1X = '0; ib.V2X = '0; ib.V0Y = '0; ib.V1Y = '0; ib.V2Y = '0;
        rst = 1'b1;
        #3;
        chk("rst_a_valid", 32'(ia.OUT_VALID), 32'(0));
        chk("rst_b_valid", 32'(ib.OUT_VALID), 32'(0));
        chk("rst_b_xmin", 32'(ib.XMIN), 32'(0));
        chk("rst_b_ymax", 32'(ib.YMAX), 32'(0));
        chk("rst_b_culled", 32'(ib.CULLED), 32'(0));
        chk("rst_a_cnt", 32'(cnt_a), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_in_ready", 32'(ia.IN_READY), 32'(1));
        chk("rst_b_in_ready", 32'(ib.IN_READY), 32'(1));
        @(negedge clk);

        // Basic box, two-cycle latency
        push_both(mk_tri(100, 200, 50, 64, 64, 128));
        tick();
        chk("t1_lat1", 32'(ib.OUT_VALID), 32'(0));
        tick();
        chk("t1_lat2", 32'(ib.OUT_VALID), 32'(1));
        chk("t1_xmin", 32'(ib.XMIN), 32'(64));
        chk("t1_xmax", 32'(ib.XMAX), 32'(192));
        chk("t1_ymin", 32'(ib.YMIN), 32'(64));
        chk("t1_ymax", 32'(ib.YMAX), 32'(128));
        chk("t1_culled", 32'(ib.CULLED), 32'(0));
        drain(20);

        // Partially left of screen, clamps to zero
        push_both(mk_tri(-200, -100, 30, 0, 10, 20));
        tick(); tick();
        chk("t2_xmin", 32'(ib.XMIN), 32'(0));
        chk("t2_xmax", 32'(ib.XMAX), 32'(0));
        chk("t2_ymax", 32'(ib.YMAX), 32'(0));
        chk("t2_culled", 32'(ib.CULLED), 32'(0));
        drain(20);

        // Entirely left of screen
        chk("t3_cnt_before", 32'(cnt_a), 32'(0));
        push_both(mk_tri(-300, -200, -100, 0, 0, 0));
        tick(); tick();
        chk("t3_a_novalid", 32'(ia.OUT_VALID), 32'(0));
        chk("t3_b_valid", 32'(ib.OUT_VALID), 32'(1));
        chk("t3_b_culled", 32'(ib.CULLED), 32'(1));
        drain(20);
        chk("t3_a_cnt", 32'(cnt_a), 32'(1));
        chk("t3_b_cnt", 32'(cnt_b), 32'(1));

        // Largest positive X must not wrap when rounded
        push_both(mk_tri(32767, 0, 100, 0, 0, 0));
        tick(); tick();
        chk("t4_xmax", 32'(ib.XMAX), 32'(20416));
        chk("t4_xmin", 32'(ib.XMIN), 32'(0));
        drain(20);

        // Back-to-back stream with OUT_READY 1,0,0,1,...
        rdy_mode = 1;
        cyc = 0;
        for (int k = 0; k < 5; k++)
            push_both(mk_tri(64 * k, 64 * k + 300, 64 * k + 10, 40 * k, 40 * k + 90, 40 * k + 5));
        drain(60);
        rdy_mode = 0;
        ia.OUT_READY = 1'b1; ib.OUT_READY = 1'b1;

        // Clear coinciding with a culled drop: clear wins
        src_a.push_back(mk_tri(-300, -200, -100, 0, 0, 0));
        tick(); tick();
        chk("t6_pre", 32'(cnt_a), 32'(1));
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        exp_a = 0;
        chk("t6_clr", 32'(cnt_a), 32'(0));
        drain(10);
        chk("t6_after", 32'(cnt_a), 32'(0));

        // Saturation of the narrow counter
        for (int k = 0; k < CNTA_MAX + 5; k++)
            src_a.push_back(mk_tri(100 + k, 200, 300, -500, -400, -300));
        drain(80);
        chk("t7_sat", 32'(cnt_a), 32'(CNTA_MAX));

        // Random triangles with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 200; k++) begin
            t = mk_tri(rand_coord(30000, 8000), rand_coord(30000, 8000), rand_coord(30000, 8000),
                       rand_coord(22000, 6000), rand_coord(22000, 6000), rand_coord(22000, 6000));
            push_both(t);
        end
        drain(3000);
        rdy_mode = 0;
        ia.OUT_READY = 1'b1; ib.OUT_READY = 1'b1;
        chk("t8_a_cnt", 32'(cnt_a), 32'(exp_a));
        chk("t8_b_cnt", 32'(cnt_b), 32'(exp_b));

        // Reset with two triangles in flight
        ia.OUT_READY = 1'b0; ib.OUT_READY = 1'b0;
        push_both(mk_tri(10, 20, 30, 10, 20, 30));
        push_both(mk_tri(40, 50, 60, 40, 50, 60));
        tick(); tick();
        chk("t9_pre_valid", 32'(ib.OUT_VALID), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t9_a_valid", 32'(ia.OUT_VALID), 32'(0));
        chk("t9_b_valid", 32'(ib.OUT_VALID), 32'(0));
        chk("t9_a_cnt", 32'(cnt_a), 32'(0));
        chk("t9_b_cnt", 32'(cnt_b), 32'(0));
        src_a.delete(); src_b.delete(); q_a.delete(); q_b.delete();
        occ_b = 0; exp_a = 0; exp_b = 0;
        @(negedge clk);
        rst = 1'b0;
        ia.OUT_READY = 1'b1; ib.OUT_READY = 1'b1;
        push_both(mk_tri(640, 700, 900, 320, 400, 500));
        tick(); tick();
        chk("t9_first_xmin", 32'(ib.XMIN), 32'(640));
        chk("t9_first_ymax", 32'(ib.YMAX), 32'(512));
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
